// File: rtl/anton_neopixel_pkg.sv
// Shared types, timing constants and helpers for the multi-channel NeoPixel serialiser.
package anton_neopixel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STREAM = 3'd3,
        ST_SYNC   = 3'd4
    } state_t;

    localparam int unsigned T1H_TICKS           = 5;
    localparam int unsigned T0H_TICKS           = 2;
    localparam int unsigned TICKS_PER_BIT       = 8;
    localparam int unsigned BITS_PER_BYTE       = 8;
    localparam int unsigned TICK_BITS           = 3;
    localparam int unsigned BIT_IDX_BITS        = 3;
    localparam int unsigned RESET_DELAY_DEFAULT = 520;

    // Ceiling log2 usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (longint unsigned p = 1; p < longint'(value); p = p << 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/anton_neopixel_lane.sv
// One output lane: byte length latch, shift/prefetch registers and registered pulse encoder.
module anton_neopixel_lane
    import anton_neopixel_pkg::*;
#(
    parameter int unsigned PIXELS_MAX = 8192,
    parameter int unsigned LEN_BITS   = clog2(PIXELS_MAX + 1)
) (
    input  logic                 clk6_4mhz,
    input  logic                 rstn,
    input  logic                 latch,
    input  logic                 mode32,
    input  logic [LEN_BITS-1:0]  chan_len,
    input  logic                 load_shift,
    input  logic                 load_pf,
    input  logic                 shift_bit,
    input  logic                 next_byte,
    input  logic                 emit,
    input  logic [TICK_BITS-1:0] tick,
    input  logic [LEN_BITS-1:0]  byte_idx,
    input  logic [7:0]           mem_byte,
    output logic [LEN_BITS-1:0]  len_next_c,
    output logic                 neo
);

    logic [LEN_BITS+1:0]  prod;
    logic [LEN_BITS-1:0]  len_bytes;
    logic [7:0]           shift;
    logic [7:0]           pf;
    logic [TICK_BITS-1:0] high_ticks;
    logic                 neo_d;

    // Byte count for the next frame: pixels * 3 (shift-add) or * 4, clamped.
    always_comb begin
        prod = mode32 ? {chan_len, 2'b00}
                      : ({2'b00, chan_len} + {1'b0, chan_len, 1'b0});
        len_next_c = (prod > (LEN_BITS+2)'(PIXELS_MAX)) ? LEN_BITS'(PIXELS_MAX)
                                                        : prod[LEN_BITS-1:0];
    end

    // Lanes past their own length stay low while longer lanes keep streaming.
    always_comb begin
        high_ticks = shift[7] ? TICK_BITS'(T1H_TICKS) : TICK_BITS'(T0H_TICKS);
        neo_d      = emit && (byte_idx < len_bytes) && (tick < high_ticks);
    end

    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) begin
            len_bytes <= '0;
            shift     <= '0;
            pf        <= '0;
            neo       <= 1'b0;
        end else begin
            if (latch) begin
                len_bytes <= len_next_c;
            end
            if (load_shift) begin
                shift <= mem_byte;
            end else if (next_byte) begin
                shift <= pf;
            end else if (shift_bit) begin
                shift <= {shift[6:0], 1'b0};
            end
            if (load_pf) begin
                pf <= mem_byte;
            end
            neo <= neo_d;
        end
    end

endmodule

// File: rtl/anton_neopixel_multi_stream.sv
// Lockstep multi-strip NeoPixel serialiser: frame FSM, bit/byte counters and shared memory port.
module anton_neopixel_multi_stream
    import anton_neopixel_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned PIXELS_MAX  = 8192,
    parameter int unsigned RESET_DELAY = RESET_DELAY_DEFAULT,
    parameter int unsigned LEN_BITS    = clog2(PIXELS_MAX + 1),
    parameter int unsigned ADDR_BITS   = clog2(PIXELS_MAX * 4)
) (
    input  logic                         clk6_4mhz,
    input  logic                         rstn,
    input  logic                         enable,
    input  logic                         start,
    input  logic                         loop,
    input  logic                         stopReq,
    input  logic                         mode32,
    input  logic [CHANNELS*LEN_BITS-1:0] chanLen,
    output logic                         memRd,
    output logic [ADDR_BITS-1:0]         memAddr,
    input  logic [CHANNELS*8-1:0]        memData,
    output logic [CHANNELS-1:0]          neoData,
    output logic                         neoState,
    output logic                         frameDone
);

    localparam int unsigned SYNC_BITS = clog2(RESET_DELAY);

    state_t                  state, state_d;
    logic [TICK_BITS-1:0]    tick, tick_d;
    logic [BIT_IDX_BITS-1:0] bitc, bitc_d;
    logic [LEN_BITS-1:0]     k, k_d;
    logic [LEN_BITS-1:0]     total, total_d;
    logic [SYNC_BITS-1:0]    sync_cnt, sync_cnt_d;
    logic                    rd_q;
    logic                    mem_rd_d;
    logic [ADDR_BITS-1:0]    mem_addr_d;
    logic                    frame_done_d;
    logic                    neo_state_d;

    logic                    restart_c;
    logic                    latch_c;
    logic                    load_shift_c;
    logic                    load_pf_c;
    logic                    shift_bit_c;
    logic                    next_byte_c;
    logic                    emit_c;
    logic [LEN_BITS-1:0]     total_next_c;
    logic [LEN_BITS-1:0]     len_next [CHANNELS];

    // Frame length is the longest lane.
    always_comb begin
        total_next_c = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (len_next[c] > total_next_c) begin
                total_next_c = len_next[c];
            end
        end
    end

    always_comb begin
        state_d      = state;
        tick_d       = tick;
        bitc_d       = bitc;
        k_d          = k;
        total_d      = total;
        sync_cnt_d   = sync_cnt;
        mem_rd_d     = 1'b0;
        mem_addr_d   = memAddr;
        frame_done_d = 1'b0;
        restart_c    = 1'b0;
        latch_c      = 1'b0;
        load_shift_c = 1'b0;
        load_pf_c    = 1'b0;
        shift_bit_c  = 1'b0;
        next_byte_c  = 1'b0;
        emit_c       = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    restart_c = start;
                end
                ST_FETCH: begin
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    load_shift_c = 1'b1;
                    state_d      = ST_STREAM;
                    tick_d       = '0;
                    bitc_d       = '0;
                    if (total > LEN_BITS'(1)) begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = ADDR_BITS'(1);
                    end
                end
                ST_STREAM: begin
                    emit_c    = 1'b1;
                    load_pf_c = rd_q;
                    tick_d    = tick + TICK_BITS'(1);
                    if (tick == TICK_BITS'(TICKS_PER_BIT - 1)) begin
                        if (bitc == BIT_IDX_BITS'(BITS_PER_BYTE - 1)) begin
                            bitc_d = '0;
                            if (k == total - LEN_BITS'(1)) begin
                                state_d    = ST_SYNC;
                                sync_cnt_d = '0;
                            end else begin
                                // Prefetched byte moves in now; request the one after it.
                                next_byte_c = 1'b1;
                                k_d         = k + LEN_BITS'(1);
                                if (((LEN_BITS+1)'(k) + (LEN_BITS+1)'(2)) < (LEN_BITS+1)'(total)) begin
                                    mem_rd_d   = 1'b1;
                                    mem_addr_d = ADDR_BITS'(k) + ADDR_BITS'(2);
                                end
                            end
                        end else begin
                            shift_bit_c = 1'b1;
                            bitc_d      = bitc + BIT_IDX_BITS'(1);
                        end
                    end
                end
                ST_SYNC: begin
                    if (sync_cnt == SYNC_BITS'(RESET_DELAY - 1)) begin
                        if (loop && !stopReq) begin
                            restart_c = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sync_cnt_d = sync_cnt + SYNC_BITS'(1);
                        if (sync_cnt == SYNC_BITS'(RESET_DELAY - 2)) begin
                            frame_done_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Frame boundary: latch lengths, then fetch byte 0 or go straight to sync.
        if (restart_c) begin
            latch_c = 1'b1;
            total_d = total_next_c;
            if (total_next_c == '0) begin
                state_d    = ST_SYNC;
                sync_cnt_d = '0;
            end else begin
                state_d    = ST_FETCH;
                mem_rd_d   = 1'b1;
                mem_addr_d = '0;
                k_d        = '0;
            end
        end

        neo_state_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            tick      <= '0;
            bitc      <= '0;
            k         <= '0;
            total     <= '0;
            sync_cnt  <= '0;
            rd_q      <= 1'b0;
            memRd     <= 1'b0;
            memAddr   <= '0;
            frameDone <= 1'b0;
            neoState  <= 1'b0;
        end else begin
            state     <= state_d;
            tick      <= tick_d;
            bitc      <= bitc_d;
            k         <= k_d;
            total     <= total_d;
            sync_cnt  <= sync_cnt_d;
            rd_q      <= memRd;
            memRd     <= mem_rd_d;
            memAddr   <= mem_addr_d;
            frameDone <= frame_done_d;
            neoState  <= neo_state_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        anton_neopixel_lane #(
            .PIXELS_MAX (PIXELS_MAX),
            .LEN_BITS   (LEN_BITS)
        ) u_lane (
            .clk6_4mhz  (clk6_4mhz),
            .rstn       (rstn),
            .latch      (latch_c),
            .mode32     (mode32),
            .chan_len   (chanLen[c*LEN_BITS +: LEN_BITS]),
            .load_shift (load_shift_c),
            .load_pf    (load_pf_c),
            .shift_bit  (shift_bit_c),
            .next_byte  (next_byte_c),
            .emit       (emit_c),
            .tick       (tick),
            .byte_idx   (k),
            .mem_byte   (memData[c*8 +: 8]),
            .len_next_c (len_next[c]),
            .neo        (neoData[c])
        );
    end

endmodule

// File: tb/tb_anton_neopixel_multi_stream.sv
// Randomised bench for the multi-stream serialiser against a per-cycle waveform model.
module tb_anton_neopixel_multi_stream;
    import anton_neopixel_pkg::*;

    localparam int unsigned CH   = 2;
    localparam int unsigned PMAX = 8192;
    localparam int          RD   = 520;
    localparam int unsigned LB   = clog2(PMAX + 1);
    localparam int unsigned AB   = clog2(PMAX * 4);
    localparam int unsigned VW   = 3 + AB + CH;

    logic              clk6_4mhz = 1'b0;
    logic              rstn = 1'b0;
    logic              enable = 1'b0;
    logic              start = 1'b0;
    logic              loop = 1'b0;
    logic              stopReq = 1'b0;
    logic              mode32 = 1'b0;
    logic [CH*LB-1:0]  chanLen = '0;
    logic              memRd;
    logic [AB-1:0]     memAddr;
    logic [CH*8-1:0]   memData;
    logic [CH-1:0]     neoData;
    logic              neoState;
    logic              frameDone;

    logic [7:0] mem_pat [CH][256];
    logic [7:0] rd_addr_q = '0;
    int m_lenb [CH];
    int m_total;
    int m_frames;
    int checks = 0;
    int errors = 0;

    anton_neopixel_multi_stream #(
        .CHANNELS   (CH),
        .PIXELS_MAX (PMAX),
        .RESET_DELAY(RD)
    ) dut (
        .clk6_4mhz(clk6_4mhz), .rstn(rstn), .enable(enable), .start(start),
        .loop(loop), .stopReq(stopReq), .mode32(mode32), .chanLen(chanLen),
        .memRd(memRd), .memAddr(memAddr), .memData(memData), .neoData(neoData),
        .neoState(neoState), .frameDone(frameDone)
    );

    always #5 clk6_4mhz = ~clk6_4mhz;

    // Memory with one cycle of read latency.
    always @(posedge clk6_4mhz) if (memRd) rd_addr_q <= memAddr[7:0];
    always_comb begin
        for (int c = 0; c < CH; c++) memData[c*8 +: 8] = mem_pat[c][rd_addr_q];
    end

    function automatic int lenbytes(input int len, input bit m);
        int b;
        b = len * (m ? 4 : 3);
        return (b > int'(PMAX)) ? int'(PMAX) : b;
    endfunction

    function automatic int period();
        return (m_total == 0) ? RD : 64 * m_total + RD + 2;
    endfunction

    // Expected {neoState, frameDone, memRd, memAddr(if rd), neoData} n cycles after start was sampled.
    function automatic logic [VW-1:0] exp_vec(input int n);
        logic [CH-1:0] neo;
        logic rd, fd, ns, b;
        int addr, p, q, s, byte_i, bit_i, tick_i;
        neo = '0; rd = 1'b0; fd = 1'b0; ns = 1'b0; addr = 0;
        p = period();
        if (n >= 1 && n <= p * m_frames) begin
            q  = n - ((n - 1) / p) * p;
            ns = 1'b1;
            fd = (q == p);
            if (m_total > 0) begin
                if (q == 1) begin
                    rd = 1'b1; addr = 0;
                end else if (q >= 3 && (q - 3) % 64 == 0 && (q - 3) / 64 < m_total - 1) begin
                    rd = 1'b1; addr = (q - 3) / 64 + 1;
                end
                s = q - 4;
                if (s >= 0 && s < 64 * m_total) begin
                    byte_i = s / 64; bit_i = (s / 8) % 8; tick_i = s % 8;
                    for (int c = 0; c < CH; c++) begin
                        if (byte_i < m_lenb[c]) begin
                            b = mem_pat[c][byte_i][7 - bit_i];
                            neo[c] = (tick_i < (b ? 5 : 2));
                        end
                    end
                end
            end
        end
        return {ns, fd, rd, rd ? AB'(addr) : AB'(0), neo};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {neoState, frameDone, memRd, memRd ? memAddr : AB'(0), neoData};
    endfunction

    task automatic set_config(input int l0, input int l1, input bit m);
        mode32 = m;
        chanLen = {LB'(l1), LB'(l0)};
        m_lenb[0] = lenbytes(l0, m);
        m_lenb[1] = lenbytes(l1, m);
        m_total = (m_lenb[0] > m_lenb[1]) ? m_lenb[0] : m_lenb[1];
        m_frames = 1;
    endtask

    task automatic fill_random();
        for (int c = 0; c < CH; c++)
            for (int a = 0; a < 256; a++) mem_pat[c][a] = 8'($urandom);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk6_4mhz);
        checks++; if (neoData !== '0) begin errors++; $display("FAIL reset_neo got %b want 0", neoData); end
        checks++; if (memRd !== 1'b0) begin errors++; $display("FAIL reset_rd got %b want 0", memRd); end
        checks++; if (memAddr !== '0) begin errors++; $display("FAIL reset_addr got %0d want 0", memAddr); end
        checks++; if (neoState !== 1'b0) begin errors++; $display("FAIL reset_state got %b want 0", neoState); end
        checks++; if (frameDone !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frameDone); end
        rstn = 1'b1; enable = 1'b1;
        repeat (2) @(negedge clk6_4mhz);
    endtask

    task automatic test_basic();
        int exp_w [8] = '{5, 2, 5, 2, 2, 5, 2, 5};
        int widths [$];
        int hi = 0, fd_cnt = 0, first_rise = -1;
        logic [VW-1:0] ev;
        for (int a = 0; a < 256; a++) begin mem_pat[0][a] = 8'hA5; mem_pat[1][a] = 8'h00; end
        set_config(1, 1, 1'b0);
        @(negedge clk6_4mhz); start = 1'b1;
        for (int n = 1; n <= period() + 4; n++) begin
            @(negedge clk6_4mhz); start = 1'b0;
            ev = exp_vec(n);
            checks++;
            if (obs_vec() !== ev) begin errors++; $display("FAIL basic n=%0d got %h want %h", n, obs_vec(), ev); end
            if (neoData[0]) begin if (first_rise < 0) first_rise = n; hi++; end
            else if (hi != 0) begin widths.push_back(hi); hi = 0; end
            if (frameDone) fd_cnt++;
        end
        checks++; if (first_rise != 4) begin errors++; $display("FAIL basic_first_rise got %0d want 4", first_rise); end
        checks++; if (widths.size() != 24) begin errors++; $display("FAIL basic_pulse_count got %0d want 24", widths.size()); end
        for (int i = 0; i < widths.size() && i < 24; i++) begin
            checks++;
            if (widths[i] != exp_w[i % 8]) begin errors++; $display("FAIL basic_width i=%0d got %0d want %0d", i, widths[i], exp_w[i % 8]); end
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", fd_cnt); end
    endtask

    task automatic test_mode32();
        int addrs [$];
        int late_hi = 0;
        logic [VW-1:0] ev;
        fill_random();
        set_config(2, 1, 1'b1);
        @(negedge clk6_4mhz); start = 1'b1;
        for (int n = 1; n <= period() + 4; n++) begin
            @(negedge clk6_4mhz); start = 1'b0;
            if (n == 6) chanLen = CH*LB'($urandom);
            ev = exp_vec(n);
            checks++;
            if (obs_vec() !== ev) begin errors++; $display("FAIL mode32 n=%0d got %h want %h", n, obs_vec(), ev); end
            if (memRd) addrs.push_back(int'(memAddr));
            if (n >= 4 + 64 * 4 && neoData[1]) late_hi++;
        end
        checks++; if (late_hi != 0) begin errors++; $display("FAIL mode32_lane1_tail got %0d highs want 0", late_hi); end
        checks++; if (addrs.size() != 8) begin errors++; $display("FAIL mode32_rd_count got %0d want 8", addrs.size()); end
        for (int i = 0; i < addrs.size(); i++) begin
            checks++;
            if (addrs[i] != i) begin errors++; $display("FAIL mode32_addr i=%0d got %0d want %0d", i, addrs[i], i); end
        end
    endtask

    task automatic test_gap();
        int rises [$];
        logic prev = 1'b0;
        logic [VW-1:0] ev;
        fill_random();
        for (int a = 0; a < 256; a++) mem_pat[0][a] = 8'hFF;
        set_config(1, 2, 1'b0);
        @(negedge clk6_4mhz); start = 1'b1;
        for (int n = 1; n <= period() + 4; n++) begin
            @(negedge clk6_4mhz); start = 1'b0;
            ev = exp_vec(n);
            checks++;
            if (obs_vec() !== ev) begin errors++; $display("FAIL gap n=%0d got %h want %h", n, obs_vec(), ev); end
            if (neoData[0] && !prev) rises.push_back(n);
            prev = neoData[0];
        end
        checks++; if (rises.size() != 24) begin errors++; $display("FAIL gap_rise_count got %0d want 24", rises.size()); end
        for (int i = 1; i < rises.size(); i++) begin
            checks++;
            if (rises[i] - rises[i-1] != 8) begin errors++; $display("FAIL gap_spacing i=%0d got %0d want 8", i, rises[i] - rises[i-1]); end
        end
    endtask

    task automatic test_zero_len();
        int rd_cnt = 0, fd_cnt = 0;
        logic [VW-1:0] ev;
        set_config(0, 0, 1'($urandom));
        @(negedge clk6_4mhz); start = 1'b1;
        for (int n = 1; n <= period() + 4; n++) begin
            @(negedge clk6_4mhz); start = 1'b0;
            ev = exp_vec(n);
            checks++;
            if (obs_vec() !== ev) begin errors++; $display("FAIL zero n=%0d got %h want %h", n, obs_vec(), ev); end
            if (memRd) rd_cnt++;
            if (frameDone) fd_cnt++;
        end
        checks++; if (rd_cnt != 0) begin errors++; $display("FAIL zero_rd_count got %0d want 0", rd_cnt); end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", fd_cnt); end
    endtask

    task automatic test_random();
        logic [VW-1:0] ev;
        for (int it = 0; it < 4; it++) begin
            fill_random();
            set_config($urandom_range(3), $urandom_range(3), 1'($urandom));
            @(negedge clk6_4mhz); start = 1'b1;
            for (int n = 1; n <= period() + 4; n++) begin
                @(negedge clk6_4mhz); start = 1'b0;
                ev = exp_vec(n);
                checks++;
                if (obs_vec() !== ev) begin errors++; $display("FAIL random it=%0d n=%0d got %h want %h", it, n, obs_vec(), ev); end
            end
        end
    endtask

    task automatic test_loop_stop();
        int fd_cnt = 0;
        int p;
        logic [VW-1:0] ev;
        fill_random();
        set_config(1, 1, 1'b1);
        m_frames = 3;
        p = period();
        loop = 1'b1;
        @(negedge clk6_4mhz); start = 1'b1;
        for (int n = 1; n <= 3 * p + 4; n++) begin
            @(negedge clk6_4mhz);
            start = (n == 30);
            if (n == 2 * p + 20) stopReq = 1'b1;
            ev = exp_vec(n);
            checks++;
            if (obs_vec() !== ev) begin errors++; $display("FAIL loop n=%0d got %h want %h", n, obs_vec(), ev); end
            if (frameDone) fd_cnt++;
        end
        checks++; if (fd_cnt != 3) begin errors++; $display("FAIL loop_done_count got %0d want 3", fd_cnt); end
        loop = 1'b0; stopReq = 1'b0; start = 1'b0;
        m_frames = 1;
    endtask

    task automatic test_abort();
        int cut;
        logic [VW-1:0] ev;
        fill_random();
        set_config(2, 2, 1'b0);
        cut = $urandom_range(200, 10);
        @(negedge clk6_4mhz); start = 1'b1;
        for (int n = 1; n <= cut; n++) begin
            @(negedge clk6_4mhz); start = 1'b0;
            ev = exp_vec(n);
            checks++;
            if (obs_vec() !== ev) begin errors++; $display("FAIL abort_pre n=%0d got %h want %h", n, obs_vec(), ev); end
        end
        enable = 1'b0;
        @(negedge clk6_4mhz);
        checks++;
        if (obs_vec() !== '0) begin errors++; $display("FAIL abort_enable got %h want 0", obs_vec()); end
        enable = 1'b1;
        repeat (2) @(negedge clk6_4mhz);
        start = 1'b1;
        for (int n = 1; n <= period() + 4; n++) begin
            @(negedge clk6_4mhz); start = 1'b0;
            ev = exp_vec(n);
            checks++;
            if (obs_vec() !== ev) begin errors++; $display("FAIL abort_replay n=%0d got %h want %h", n, obs_vec(), ev); end
        end
        cut = $urandom_range(300, 50);
        start = 1'b1;
        for (int n = 1; n <= cut; n++) begin
            @(negedge clk6_4mhz); start = 1'b0;
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({obs_vec(), memAddr} !== '0) begin errors++; $display("FAIL abort_rstn got %h addr %0d want 0", obs_vec(), memAddr); end
        @(negedge clk6_4mhz); rstn = 1'b1;
        @(negedge clk6_4mhz); start = 1'b1;
        for (int n = 1; n <= period() + 4; n++) begin
            @(negedge clk6_4mhz); start = 1'b0;
            ev = exp_vec(n);
            checks++;
            if (obs_vec() !== ev) begin errors++; $display("FAIL abort_rstn_replay n=%0d got %h want %h", n, obs_vec(), ev); end
        end
    endtask

    initial begin
        fill_random();
        m_total = 0; m_frames = 1;
        m_lenb[0] = 0; m_lenb[1] = 0;
        test_reset();
        test_basic();
        test_mode32();
        test_gap();
        test_zero_len();
        test_random();
        test_loop_stop();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
